clock_mode_ctrl: RTL and testbench
==================================

Name: clock_mode_ctrl

Overview:
Central sequencer for the lab 2 alarm clock datapath. It decodes the manual buttons into a registered mode: RUN, TSET (time set) or ASET (alarm set). It drives the count enables of the time counters (seconds, minutes, hours, AM/PM) and the alarm counters (minutes, hours, AM/PM), and the display-source select. It also owns the buzzer state machine, which handles alarm trigger, snooze and ring timeout. It sits between the button/comparator inputs and the ct_mod_N/regce instances in the top level.

Parameters:
RING_SECS, 60, clk cycles (seconds) buzz stays on before auto-silence; must be >= 1.
SNZ_SECS, 300, clk cycles buzz stays off during snooze before re-ringing; must be >= 1.
CW, 9, width of ring/snooze down-counter; must satisfy 2^CW > max(RING_SECS, SNZ_SECS).

Ports:
clk  in  1  single system clock (1 Hz Pulse); all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
timeset  in  1  level; request time-set mode.
alarmset  in  1  level; request alarm-set mode.
minadv  in  1  level; advance minutes by one per clk while high, in set modes.
hrsadv  in  1  level; advance hours by one per clk while high, in set modes.
alarmon  in  1  level; alarm armed.
snooze  in  1  level; snooze request.
smax  in  1  time seconds counter at terminal count (59).
mmax  in  1  time minutes counter at terminal count (59).
hmax  in  1  time hours counter at terminal count.
ahmax  in  1  alarm hours counter at terminal count.
match  in  1  alarm comparator: time hrs/min/pm equal to alarm hrs/min/pm.
ts_en  out  1  time seconds counter enable.
tm_en  out  1  time minutes counter enable.
th_en  out  1  time hours counter enable.
tpm_en  out  1  time AM/PM toggle enable.
am_en  out  1  alarm minutes enable.
ah_en  out  1  alarm hours enable.
apm_en  out  1  alarm AM/PM toggle enable.
disp_alarm  out  1  1 = min/hr displays show alarm registers; 0 = time.
mode  out  2  00 RUN, 01 TSET, 10 ASET; 11 unused.
buzz  out  1  buzzer drive.

Behaviour:
- Reset (sync, rst=1 at edge): mode=RUN; buzzer FSM=IDLE; down-counter=0; match_d=0. Consequently buzz=0, disp_alarm=0. Enables are combinational from state and inputs, so their post-reset values follow the RUN equations.
- Mode FSM (registered; next state takes effect one clk after the button changes):
  - RUN -> TSET if timeset=1.
  - RUN -> ASET if timeset=0 and alarmset=1. timeset has priority when both are high.
  - TSET -> RUN when timeset=0. alarmset is ignored while in TSET.
  - ASET -> RUN when alarmset=0. timeset is ignored while in ASET.
  - Encoding 11 is never reached; if it occurs, it returns to RUN on the next edge.
- Enables (combinational, same cycle):
  - RUN: ts_en=1; tm_en=smax; th_en=smax&mmax; tpm_en=smax&mmax&hmax. All alarm enables are 0.
  - TSET: ts_en=0 (seconds stall); tm_en=minadv; th_en=hrsadv; tpm_en=hrsadv&hmax. Minute advance does not carry into hours. All alarm enables are 0.
  - ASET: time enables follow the RUN equations (the clock keeps running); am_en=minadv; ah_en=hrsadv; apm_en=hrsadv&ahmax.
  - disp_alarm = (mode==ASET).
- Buzzer FSM (Moore; buzz = state==RINGING). Defined edge: trig = match & ~match_d, where match_d is registered every cycle.
  - IDLE -> RINGING on trig & alarmon & mode==RUN. Load cnt=RING_SECS-1.
  - RINGING:
    - alarmon=0 or mode!=RUN -> IDLE.
    - else snooze=1 -> SNOOZE, load cnt=SNZ_SECS-1.
    - else cnt==0 -> IDLE.
    - else cnt-1.
    - Net effect: buzz is high exactly RING_SECS cycles if undisturbed.
  - SNOOZE:
    - alarmon=0 or mode!=RUN -> IDLE.
    - else cnt==0 -> RINGING, load cnt=RING_SECS-1.
    - else cnt-1.
    - Net effect: buzz is low exactly SNZ_SECS cycles.
  - trig while in RINGING or SNOOZE: ignored.
  - A match held high retriggers nothing; only a new rising edge does.
  - match=1 on the first cycle after reset counts as a rising edge.
  - snooze held high through re-ring: it re-enters SNOOZE one cycle after RINGING is entered.
- rst asserted mid-ring or mid-snooze: buzz=0 after that edge.

Test Plan:
1. rst=1 for 2 clks, all inputs 0 -> mode=00, buzz=0, ts_en=1, all other enables 0. Then drive smax=mmax=hmax=1 -> tm_en=th_en=tpm_en=1 in the same cycle.
2. timeset=1 and alarmset=1 together from RUN -> mode=01 next clk, ts_en=0. minadv=1 for 3 clks -> tm_en=1 for 3 cycles, th_en=0. Release timeset -> mode=00 next clk.
3. ASET with hrsadv=1, ahmax=1 -> ah_en=1, apm_en=1, disp_alarm=1, tm_en still equals smax.
4. RING_SECS=4: alarmon=1, match rises and is held 10 clks -> buzz=1 exactly 4 cycles then 0; no retrigger while match stays high.
5. RING_SECS=4, SNZ_SECS=3: snooze pulse on the 2nd ringing cycle -> buzz=0 for 3 cycles, then buzz=1 for 4 cycles. Drop alarmon during the second ring -> buzz=0 next clk.
6. Ringing, then timeset=1 -> buzz=0 one clk after mode=01. Separately, rst mid-SNOOZE -> IDLE, buzz stays 0 after SNZ_SECS expires.

Source files
------------

// File: rtl/clock_mode_ctrl.sv
// Alarm clock sequencer: button mode decode, counter enables and
// the buzzer ring/snooze state machine.
module clock_mode_ctrl #(
    parameter int RING_SECS = 60,
    parameter int SNZ_SECS  = 300,
    parameter int CW        = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       timeset,
    input  logic       alarmset,
    input  logic       minadv,
    input  logic       hrsadv,
    input  logic       alarmon,
    input  logic       snooze,
    input  logic       smax,
    input  logic       mmax,
    input  logic       hmax,
    input  logic       ahmax,
    input  logic       match,
    output logic       ts_en,
    output logic       tm_en,
    output logic       th_en,
    output logic       tpm_en,
    output logic       am_en,
    output logic       ah_en,
    output logic       apm_en,
    output logic       disp_alarm,
    output logic [1:0] mode,
    output logic       buzz
);

    localparam logic [1:0] MODE_RUN  = 2'b00;
    localparam logic [1:0] MODE_TSET = 2'b01;
    localparam logic [1:0] MODE_ASET = 2'b10;

    localparam logic [1:0] BZ_IDLE = 2'b00;
    localparam logic [1:0] BZ_RING = 2'b01;
    localparam logic [1:0] BZ_SNZ  = 2'b10;

    localparam logic [CW-1:0] RING_LD = CW'(RING_SECS - 1);
    localparam logic [CW-1:0] SNZ_LD  = CW'(SNZ_SECS - 1);

    logic [1:0]    r_mode;
    logic [1:0]    w_mode_nxt;
    logic [1:0]    r_bz;
    logic [1:0]    w_bz_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_match_d;
    logic          w_trig;
    logic          w_run_ok;

    // Mode FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode <= MODE_RUN;
        end else begin
            r_mode <= w_mode_nxt;
        end
    end

    always_comb begin
        w_mode_nxt = MODE_RUN;
        case (r_mode)
            MODE_RUN: begin
                if (timeset) begin
                    w_mode_nxt = MODE_TSET;
                end else if (alarmset) begin
                    w_mode_nxt = MODE_ASET;
                end else begin
                    w_mode_nxt = MODE_RUN;
                end
            end
            MODE_TSET: w_mode_nxt = timeset ? MODE_TSET : MODE_RUN;
            MODE_ASET: w_mode_nxt = alarmset ? MODE_ASET : MODE_RUN;
            default:   w_mode_nxt = MODE_RUN;
        endcase
    end

    // Counter enables; the clock keeps running while the alarm is set
    always_comb begin
        ts_en  = 1'b1;
        tm_en  = smax;
        th_en  = smax & mmax;
        tpm_en = smax & mmax & hmax;
        am_en  = 1'b0;
        ah_en  = 1'b0;
        apm_en = 1'b0;
        case (r_mode)
            MODE_TSET: begin
                ts_en  = 1'b0;
                tm_en  = minadv;
                th_en  = hrsadv;
                tpm_en = hrsadv & hmax;
            end
            MODE_ASET: begin
                am_en  = minadv;
                ah_en  = hrsadv;
                apm_en = hrsadv & ahmax;
            end
            default: begin
                ts_en = 1'b1;
            end
        endcase
        disp_alarm = (r_mode == MODE_ASET);
        mode       = r_mode;
    end

    assign w_trig   = match & ~r_match_d;
    assign w_run_ok = alarmon & (r_mode == MODE_RUN);

    // Buzzer FSM: state register, down-counter and match edge history
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bz      <= BZ_IDLE;
            r_cnt     <= '0;
            r_match_d <= 1'b0;
        end else begin
            r_bz      <= w_bz_nxt;
            r_cnt     <= w_cnt_nxt;
            r_match_d <= match;
        end
    end

    always_comb begin
        w_bz_nxt  = r_bz;
        w_cnt_nxt = r_cnt;
        case (r_bz)
            BZ_IDLE: begin
                if (w_trig && w_run_ok) begin
                    w_bz_nxt  = BZ_RING;
                    w_cnt_nxt = RING_LD;
                end
            end
            BZ_RING: begin
                if (!w_run_ok) begin
                    w_bz_nxt  = BZ_IDLE;
                    w_cnt_nxt = '0;
                end else if (snooze) begin
                    w_bz_nxt  = BZ_SNZ;
                    w_cnt_nxt = SNZ_LD;
                end else if (r_cnt == '0) begin
                    w_bz_nxt  = BZ_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            BZ_SNZ: begin
                if (!w_run_ok) begin
                    w_bz_nxt  = BZ_IDLE;
                    w_cnt_nxt = '0;
                end else if (r_cnt == '0) begin
                    w_bz_nxt  = BZ_RING;
                    w_cnt_nxt = RING_LD;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_bz_nxt  = BZ_IDLE;
                w_cnt_nxt = '0;
            end
        endcase
    end

    always_comb begin
        buzz = (r_bz == BZ_RING);
    end

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Scoreboard bench for clock_mode_ctrl with short ring/snooze times.
module tb_clock_mode_ctrl;

    logic clk = 1'b0;
    logic rst, timeset, alarmset, minadv, hrsadv, alarmon, snooze;
    logic smax, mmax, hmax, ahmax, match;
    logic ts_en, tm_en, th_en, tpm_en, am_en, ah_en, apm_en;
    logic disp_alarm, buzz;
    logic [1:0] mode;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string      tag;
        logic [10:0] v;
    } sb_t;
    sb_t sb[$];

    clock_mode_ctrl #(.RING_SECS(4), .SNZ_SECS(3), .CW(9)) dut (
        .clk(clk), .rst(rst), .timeset(timeset), .alarmset(alarmset),
        .minadv(minadv), .hrsadv(hrsadv), .alarmon(alarmon),
        .snooze(snooze), .smax(smax), .mmax(mmax), .hmax(hmax),
        .ahmax(ahmax), .match(match), .ts_en(ts_en), .tm_en(tm_en),
        .th_en(th_en), .tpm_en(tpm_en), .am_en(am_en), .ah_en(ah_en),
        .apm_en(apm_en), .disp_alarm(disp_alarm), .mode(mode),
        .buzz(buzz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Expected outputs for a given registered mode/buzz and current inputs
    function automatic logic [10:0] exp_vec(input logic [1:0] m,
                                             input logic bz);
        logic ts, tm, th, tpm, am, ah, apm;
        ts  = (m != 2'b01);
        tm  = (m == 2'b01) ? minadv : smax;
        th  = (m == 2'b01) ? hrsadv : (smax & mmax);
        tpm = (m == 2'b01) ? (hrsadv & hmax) : (smax & mmax & hmax);
        am  = (m == 2'b10) & minadv;
        ah  = (m == 2'b10) & hrsadv;
        apm = (m == 2'b10) & hrsadv & ahmax;
        return {m, (m == 2'b10), bz, ts, tm, th, tpm, am, ah, apm};
    endfunction

    // Push expectation for this cycle, then let the next edge happen
    task automatic cyc(input string tag, input logic [1:0] m,
                       input logic bz);
        sb_t e;
        e.tag = tag;
        e.v   = exp_vec(m, bz);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            sb_t e;
            e = sb.pop_front();
            chk(e.tag, 32'({mode, disp_alarm, buzz, ts_en, tm_en, th_en,
                            tpm_en, am_en, ah_en, apm_en}), 32'(e.v));
        end
    end

    initial begin
        rst = 1; timeset = 0; alarmset = 0; minadv = 0; hrsadv = 0;
        alarmon = 0; snooze = 0; smax = 0; mmax = 0; hmax = 0;
        ahmax = 0; match = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;

        // 1: reset state and RUN carries
        cyc("rst_state", 2'b00, 1'b0);
        smax = 1; mmax = 1; hmax = 1;
        cyc("run_carry", 2'b00, 1'b0);
        smax = 0; mmax = 1; hmax = 1;
        cyc("run_nosmax", 2'b00, 1'b0);
        mmax = 0; hmax = 0;

        // 2: timeset priority, minute advance, release
        timeset = 1; alarmset = 1;
        cyc("run_to_tset", 2'b00, 1'b0);
        minadv = 1; smax = 1; mmax = 1;
        for (int i = 0; i < 3; i++) cyc("tset_minadv", 2'b01, 1'b0);
        minadv = 0; hrsadv = 1; hmax = 1;
        cyc("tset_hrsadv", 2'b01, 1'b0);
        hrsadv = 0; hmax = 0; timeset = 0; alarmset = 0;
        cyc("tset_release", 2'b01, 1'b0);
        cyc("back_run", 2'b00, 1'b0);

        // 3: alarm set
        alarmset = 1; timeset = 1;
        cyc("run_to_tset_pri", 2'b00, 1'b0);
        timeset = 0;
        cyc("tset_exit", 2'b01, 1'b0);
        cyc("run_to_aset", 2'b00, 1'b0);
        hrsadv = 1; ahmax = 1; smax = 1; timeset = 1;
        cyc("aset_hrs", 2'b10, 1'b0);
        smax = 0; minadv = 1;
        cyc("aset_min", 2'b10, 1'b0);
        hrsadv = 0; ahmax = 0; minadv = 0; alarmset = 0; timeset = 0;
        cyc("aset_release", 2'b10, 1'b0);
        cyc("aset_back_run", 2'b00, 1'b0);

        // 4: ring timeout with match held high
        alarmon = 1;
        cyc("ring_pre", 2'b00, 1'b0);
        match = 1;
        for (int i = 0; i < 10; i++)
            cyc("ring_hold", 2'b00, (i >= 1 && i <= 4));
        match = 0;
        cyc("ring_after", 2'b00, 1'b0);

        // 5: snooze then re-ring, drop alarmon in second ring
        match = 1;
        cyc("snz_trig", 2'b00, 1'b0);
        cyc("snz_ring1", 2'b00, 1'b1);
        snooze = 1;
        cyc("snz_ring2", 2'b00, 1'b1);
        snooze = 0;
        for (int i = 0; i < 3; i++) cyc("snz_quiet", 2'b00, 1'b0);
        cyc("rering1", 2'b00, 1'b1);
        cyc("rering2", 2'b00, 1'b1);
        alarmon = 0;
        cyc("rering3_off", 2'b00, 1'b1);
        cyc("alarmoff", 2'b00, 1'b0);
        cyc("alarmoff2", 2'b00, 1'b0);
        match = 0;
        cyc("m_low", 2'b00, 1'b0);

        // 6a: timeset while ringing
        alarmon = 1; match = 1;
        cyc("ts_trig", 2'b00, 1'b0);
        cyc("ts_ring", 2'b00, 1'b1);
        timeset = 1;
        cyc("ts_req", 2'b00, 1'b1);
        cyc("ts_mode", 2'b01, 1'b1);
        timeset = 0;
        cyc("ts_silent", 2'b01, 1'b0);
        cyc("ts_back", 2'b00, 1'b0);
        match = 0;
        cyc("ts_mlow", 2'b00, 1'b0);

        // 6b: reset during snooze
        match = 1;
        cyc("rs_trig", 2'b00, 1'b0);
        snooze = 1;
        cyc("rs_ring", 2'b00, 1'b1);
        snooze = 0; rst = 1; match = 0;
        cyc("rs_snz", 2'b00, 1'b0);
        rst = 0;
        for (int i = 0; i < 6; i++) cyc("rs_idle", 2'b00, 1'b0);

        @(negedge clk);
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
